// File: rtl/featuremap_padded_feeder_pkg.sv
// featuremap_padded_feeder_pkg
// Layer-wide constants shared by the padded feeder and its raster counter:
// pixel packing, channel slice offsets, FSM state encoding and padded
// frame dimensions (defaults; modules derive their own from parameters).
package featuremap_padded_feeder_pkg;

  localparam int FM_DATA_WIDTH = 32;
  localparam int FM_WIDTH      = 32;
  localparam int FM_HEIGHT     = 32;

  localparam int PIXEL_W = 3 * FM_DATA_WIDTH;

  // Channel slice index inside a packed pixel: slice n is [n*DW +: DW]
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // One pad pixel on each side
  function automatic int padded(input int n);
    return n + 2;
  endfunction

  localparam int PW = padded(FM_WIDTH);
  localparam int PH = padded(FM_HEIGHT);

endpackage

// File: rtl/pad_raster_counter.sv
// pad_raster_counter
// Row-major walk over the padded (HEIGHT+2) x (WIDTH+2) raster.
//   clk, rst     clock, async active-low reset
//   advance      step to the next raster position
//   clear        return to (0,0); wins over advance
//   row, col     current padded position
//   pad          current position is on the zero border
//   last         current position is the final one (HEIGHT+1, WIDTH+1)
//   addr         unpadded RAM address of the position, 0 on the border
module pad_raster_counter
  import featuremap_padded_feeder_pkg::*;
#(
  parameter int WIDTH      = FM_WIDTH,
  parameter int HEIGHT     = FM_HEIGHT,
  parameter int ADDR_WIDTH = 10,
  parameter int RW         = $clog2(HEIGHT + 2),
  parameter int CW         = $clog2(WIDTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  advance,
  input  logic                  clear,
  output logic [RW-1:0]         row,
  output logic [CW-1:0]         col,
  output logic                  pad,
  output logic                  last,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [CW-1:0] COL_LAST = CW'(padded(WIDTH) - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(padded(HEIGHT) - 1);

  logic                  row_end, col_end;
  logic [ADDR_WIDTH-1:0] row_m1, col_m1;

  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);
  assign pad     = (row == '0) || row_end || (col == '0) || col_end;
  assign last    = row_end && col_end;

  // Modular arithmetic in ADDR_WIDTH bits gives the truncated address directly
  assign row_m1 = ADDR_WIDTH'(row) - ADDR_WIDTH'(1);
  assign col_m1 = ADDR_WIDTH'(col) - ADDR_WIDTH'(1);
  assign addr   = pad ? '0 : (row_m1 * ADDR_WIDTH'(WIDTH) + col_m1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/featuremap_padded_feeder.sv
// featuremap_padded_feeder
// Streams an unpadded HEIGHT x WIDTH RGB image from a synchronous-read pixel
// RAM as a zero-padded (HEIGHT+2) x (WIDTH+2) raster into the featuremap FIFO.
//   clk, rst        clock, async active-low reset
//   start           one-cycle frame request (ignored while busy)
//   fifo_full       FIFO almost-full (<= 2 free entries): stalls issue
//   mem_rdata       RAM read data, valid one cycle after mem_rden
//   mem_rden        RAM read strobe (combinational)
//   mem_addr        RAM address (combinational, 0 when not reading)
//   data_out        packed pixel {B,G,R}, R in the low slice
//   data_fifo_wren  registered FIFO write enable
//   busy            frame in progress (RUN, DRAIN, DONE)
//   done            one-cycle pulse the cycle after the last write
module featuremap_padded_feeder
  import featuremap_padded_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = FM_DATA_WIDTH,
  parameter int WIDTH      = FM_WIDTH,
  parameter int HEIGHT     = FM_HEIGHT,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    fifo_full,
  input  logic [3*DATA_WIDTH-1:0] mem_rdata,
  output logic                    mem_rden,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [3*DATA_WIDTH-1:0] data_out,
  output logic                    data_fifo_wren,
  output logic                    busy,
  output logic                    done
);

  localparam int RW = $clog2(HEIGHT + 2);
  localparam int CW = $clog2(WIDTH + 2);

  logic [1:0]            state, state_nx;
  logic                  issue, clear;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  pad, last;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  s1_valid, s1_pad;

  assign clear = (state == ST_IDLE) && start;
  assign issue = (state == ST_RUN) && !fifo_full;

  pad_raster_counter #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .advance (issue),
    .clear   (clear),
    .row     (row),
    .col     (col),
    .pad     (pad),
    .last    (last),
    .addr    (addr)
  );

  assign mem_rden = issue && !pad;
  assign mem_addr = mem_rden ? addr : '0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (issue && last) state_nx = ST_DRAIN;
      // No issue happens in DRAIN, so once stage 1 is empty the output
      // register empties on this same edge; DONE lands right after the
      // last write.
      ST_DRAIN: if (!s1_valid) state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Stage 1: tracks the read in flight (RAM data arrives next cycle)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_pad   <= 1'b0;
    end else begin
      s1_valid <= issue;
      if (issue) s1_pad <= pad;
    end
  end

  // Output register: border pixels are forced to zero, data holds when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out       <= '0;
      data_fifo_wren <= 1'b0;
    end else begin
      data_fifo_wren <= s1_valid;
      if (s1_valid) data_out <= s1_pad ? '0 : mem_rdata;
    end
  end

  // Interior reads never touch the border rows/cols
  a_rden_interior: assert property (@(posedge clk) disable iff (!rst)
    mem_rden |-> (row != '0 && col != '0));

endmodule
